// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS sequential divider.
// Holds the FSM state encoding, the DIV/DIVU funct codes and the counter-width helper.
package mips_div_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_FIX  = 2'd2
   } div_state_e;

   localparam logic [5:0] FN_DIV  = 6'h1A;
   localparam logic [5:0] FN_DIVU = 6'h1B;

   // Smallest bit count able to index 0..width-1; never below one bit.
   function automatic int div_cnt_width(input int width);
      int w;
      w = 32'sd1;
      while ((32'sd1 << w) < width) begin
         w = w + 32'sd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/mips_seq_divider_if.sv
// Request/result bundle between the ALU control logic and the sequential divider.
interface mips_seq_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic             abort;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, abort, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, abort, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/mips_div_step.sv
// One restoring-division step on unsigned magnitudes: shift {rem,quo} left, try to subtract.
// Purely combinational so several copies can be chained for multi-bit iterations.
module mips_div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] rem_in,
   input  logic [WIDTH-1:0] quo_in,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem_out,
   output logic [WIDTH-1:0] quo_out
);

   logic [WIDTH:0] shifted_s;
   logic [WIDTH:0] trial_s;
   logic           fits_s;

   // Trial subtraction; the extra top bit acts as the borrow/sign of the trial.
   always_comb begin
      shifted_s = {rem_in, quo_in[WIDTH-1]};
      trial_s   = shifted_s - {1'b0, divisor};
      fits_s    = ~trial_s[WIDTH];
      if (fits_s) begin
         rem_out = trial_s[WIDTH-1:0];
      end else begin
         rem_out = shifted_s[WIDTH-1:0];
      end
      quo_out = {quo_in[WIDTH-2:0], fits_s};
   end

endmodule

// File: rtl/mips_seq_divider.sv
// Iterative restoring divider (one quotient bit per clock) for the MIPS DIV/DIVU path.
// Results stay registered for HI/LO writeback until the next completed operation.
module mips_seq_divider
   import mips_div_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter bit SIGNED_EN = 1'b1
) (
   input logic                clk,
   input logic                rst_n,
   mips_seq_divider_if.slave  bus
);

   localparam int             CW      = div_cnt_width(WIDTH);
   localparam logic [CW-1:0]  CNT_ONE = CW'(1);
   localparam logic [CW-1:0]  CNT_TOP = CW'(WIDTH - 1);

   div_state_e       state_r, state_nxt_s;
   logic [CW-1:0]    count_r;
   logic [WIDTH-1:0] rem_r, quo_r, dsr_r;
   logic             neg_q_r, neg_r_r, dbz_r;

   logic             busy_r, done_r, div_by_zero_r;
   logic [WIDTH-1:0] quotient_r, remainder_r;

   logic             a_neg_s, b_neg_s, zero_div_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;
   logic [WIDTH-1:0] step_rem_s, step_quo_s;
   logic [WIDTH-1:0] q_fix_s, r_fix_s;

   // Operand sign split; MIN_INT magnitude is fine as an unsigned WIDTH-bit value.
   always_comb begin
      a_neg_s    = SIGNED_EN & bus.is_signed & bus.dividend[WIDTH-1];
      b_neg_s    = SIGNED_EN & bus.is_signed & bus.divisor[WIDTH-1];
      a_mag_s    = a_neg_s ? -bus.dividend : bus.dividend;
      b_mag_s    = b_neg_s ? -bus.divisor  : bus.divisor;
      zero_div_s = (bus.divisor == {WIDTH{1'b0}});
   end

   mips_div_step #(.WIDTH(WIDTH)) u_step (
      .rem_in  (rem_r),
      .quo_in  (quo_r),
      .divisor (dsr_r),
      .rem_out (step_rem_s),
      .quo_out (step_quo_s)
   );

   // Final sign fix-up; on divide-by-zero quo_r carries the raw dividend.
   always_comb begin
      if (dbz_r) begin
         q_fix_s = {WIDTH{1'b1}};
         r_fix_s = quo_r;
      end else begin
         q_fix_s = neg_q_r ? -quo_r : quo_r;
         r_fix_s = neg_r_r ? -rem_r : rem_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= DIV_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort only matters once an operation is in flight.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         DIV_IDLE: begin
            if (bus.start) begin
               state_nxt_s = zero_div_s ? DIV_FIX : DIV_RUN;
            end else begin
               state_nxt_s = DIV_IDLE;
            end
         end
         DIV_RUN: begin
            if (bus.abort) begin
               state_nxt_s = DIV_IDLE;
            end else if (count_r == {CW{1'b0}}) begin
               state_nxt_s = DIV_FIX;
            end else begin
               state_nxt_s = DIV_RUN;
            end
         end
         DIV_FIX: begin
            state_nxt_s = DIV_IDLE;
         end
         default: begin
            state_nxt_s = DIV_IDLE;
         end
      endcase
   end

   // Working registers: operand capture in IDLE, one restoring step per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= {CW{1'b0}};
         rem_r   <= {WIDTH{1'b0}};
         quo_r   <= {WIDTH{1'b0}};
         dsr_r   <= {WIDTH{1'b0}};
         neg_q_r <= 1'b0;
         neg_r_r <= 1'b0;
         dbz_r   <= 1'b0;
      end else begin
         case (state_r)
            DIV_IDLE: begin
               if (bus.start) begin
                  count_r <= CNT_TOP;
                  rem_r   <= {WIDTH{1'b0}};
                  quo_r   <= zero_div_s ? bus.dividend : a_mag_s;
                  dsr_r   <= b_mag_s;
                  neg_q_r <= a_neg_s ^ b_neg_s;
                  neg_r_r <= a_neg_s;
                  dbz_r   <= zero_div_s;
               end
            end
            DIV_RUN: begin
               rem_r   <= step_rem_s;
               quo_r   <= step_quo_s;
               count_r <= count_r - CNT_ONE;
            end
            default: begin
               count_r <= count_r;
            end
         endcase
      end
   end

   // Registered handshake and result outputs; results only move on an unaborted FIX.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r        <= 1'b0;
         done_r        <= 1'b0;
         quotient_r    <= {WIDTH{1'b0}};
         remainder_r   <= {WIDTH{1'b0}};
         div_by_zero_r <= 1'b0;
      end else begin
         busy_r <= (state_nxt_s != DIV_IDLE);
         if ((state_r == DIV_FIX) && !bus.abort) begin
            done_r        <= 1'b1;
            quotient_r    <= q_fix_s;
            remainder_r   <= r_fix_s;
            div_by_zero_r <= dbz_r;
         end else begin
            done_r        <= 1'b0;
         end
      end
   end

   assign bus.busy        = busy_r;
   assign bus.done        = done_r;
   assign bus.quotient    = quotient_r;
   assign bus.remainder   = remainder_r;
   assign bus.div_by_zero = div_by_zero_r;

endmodule
